line_buffer: RTL and testbench
==============================

LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 Parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 600, active lines per frame.
REQ-003 Parameter DATA_W, default 24, pixel width; packed {R[23:16], G[15:8], B[7:0]}.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 s_valid  in  1  upstream pixel valid.
REQ-008 s_ready  out  1  block accepts a pixel.
REQ-009 s_data  in  DATA_W  upstream pixel.
REQ-010 s_last  in  1  marks the final pixel of a line.
REQ-011 pix_en  in  1  pixel-rate enable, high one clk in two.
REQ-012 count  in  11  horizontal pixel counter from the timing generator.
REQ-013 reset_count  in  10  line counter from the timing generator.
REQ-014 red, green, blue  out  8 each  pixel to the quantiser.
REQ-015 underrun  out  1  sticky: an active pixel was shown from an unfilled bank.
REQ-016 line_err  out  1  sticky: s_last was misplaced.

Function
REQ-017 Storage SHALL be two banks (0, 1), each H_ACTIVE x DATA_W, with a full bit per bank.
REQ-018 Write FSM states SHALL be FILL (s_ready=1) and WAIT (s_ready=0).
REQ-019 In FILL, a beat is accepted when s_valid && s_ready: write to bank wr_bank at wr_addr, then wr_addr+1.
REQ-020 A line closes on an accepted beat with s_last=1 or wr_addr==H_ACTIVE-1, whichever comes first.
REQ-021 On line close, the block SHALL set full[wr_bank], toggle wr_bank, and clear wr_addr to 0.
REQ-022 After a close, the next state SHALL be WAIT if the new wr_bank is full, else FILL.
REQ-023 WAIT SHALL move to FILL the cycle after full[wr_bank] clears.
REQ-024 line_err SHALL set if s_last=1 with wr_addr!=H_ACTIVE-1, or wr_addr==H_ACTIVE-1 with s_last=0.
REQ-025 On a short line, unwritten entries SHALL keep stale data.
REQ-026 Active pixel: pix_en=1 && count<H_ACTIVE && reset_count<V_ACTIVE.
REQ-027 On each pix_en cycle, red/green/blue SHALL register bank rd_bank at address count: latency 1 pix_en, registered read.
REQ-028 Outputs SHALL be 0 for non-active pixels, and for active pixels while full[rd_bank]=0.
REQ-029 underrun SHALL set on any active pixel with full[rd_bank]=0.
REQ-030 At an active pixel with count==H_ACTIVE-1 and full[rd_bank]=1, the block SHALL clear full[rd_bank] and toggle rd_bank.
REQ-031 If full[rd_bank]=0 at line end, rd_bank SHALL NOT toggle.
REQ-032 Simultaneous write-close to one bank and read-release of the other SHALL both take effect.
REQ-033 A close and a full-check on the same bank in one cycle: the reader SHALL see the pre-edge full value.
REQ-034 Outputs SHALL hold between pix_en cycles.

Reset
REQ-035 On rst: full=2'b00, wr_bank=0, rd_bank=0, wr_addr=0, state FILL.
REQ-036 On rst: red/green/blue=0, underrun=0, line_err=0; RAM contents need not be cleared.
REQ-037 rst mid-line SHALL discard the partial line; the next accepted beat writes bank 0, address 0.

Structure
REQ-038 Package vga_pkg SHALL hold H_ACTIVE=800, V_ACTIVE=600, H_TOTAL=1040, V_TOTAL=666, DATA_W=24 and the write-FSM state type.
REQ-039 One sub-module, line_ram (simple dual-port, one write port, one registered read port), SHALL be instantiated per bank.

Verification
REQ-040 After rst, stream 800 beats (value=index, s_last on beat 799) -> s_ready stays 1, full=01, wr_bank=1, line_err=0.
REQ-041 Stream 2 lines, then run line 0 of the timing count -> red/green/blue = beat index, 1 pix_en late; full[0] clears at count 799.
REQ-042 Stream 3 lines with no read -> s_ready drops after beat 1599; it rises 1 clk after the first read line end; the third line lands in bank 0.
REQ-043 No writes, active display runs -> outputs 0, underrun=1 from the first active pixel, rd_bank stays 0.
REQ-044 s_last on beat 399 -> line_err=1, bank closes at 400 beats, next beat writes address 0 of the other bank.
REQ-045 Assert rst at beat 300 of a line -> s_ready=1, full=00; the next 800 beats fill bank 0 with no line_err.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the write-side FSM state type used by the
// line buffer.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int H_TOTAL  = 1040;
  localparam int V_TOTAL  = 666;
  localparam int DATA_W   = 24;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } wr_state_t;

endpackage

// File: rtl/line_buffer_if.sv
// Valid/ready pixel stream feeding the line buffer: master is the upstream
// producer, slave is the line buffer.
interface line_buffer_if #(
  parameter int DATA_W = vga_pkg::DATA_W
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/line_ram.sv
// One line of pixel storage: a single write port and a registered read port
// that only advances when re is high.
module line_ram #(
  parameter int DEPTH  = 800,
  parameter int DATA_W = 24,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer.sv
// Ping-pong line buffer: the stream side fills one bank while the display side
// reads the other at pixel rate; full bits hand banks between the two sides.
module line_buffer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int DATA_W   = vga_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  line_buffer_if.slave stream,
  input  logic         pix_en,
  input  logic [10:0]  count,
  input  logic [9:0]   reset_count,
  output logic [7:0]   red,
  output logic [7:0]   green,
  output logic [7:0]   blue,
  output logic         underrun,
  output logic         line_err
);

  localparam int AW = $clog2(H_ACTIVE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACTIVE - 1);

  wr_state_t         state;
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic              sel;
  logic              shown;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] rdata [2];
  logic [DATA_W-1:0] pixel;
  logic              accept;
  logic              at_end;
  logic              close_line;
  logic              active;
  logic              release_line;
  logic [1:0]        set_mask;
  logic [1:0]        clr_mask;

  assign stream.s_ready = (state == FILL);
  assign accept         = stream.s_valid && (state == FILL);
  assign at_end         = (wr_addr == LAST_ADDR);
  assign close_line     = accept && (stream.s_last || at_end);
  assign active         = pix_en && (count < 11'(H_ACTIVE)) && (reset_count < 10'(V_ACTIVE));
  assign release_line   = active && full[rd_bank] && (count == 11'(H_ACTIVE - 1));

  // Close and release never target the same bank, so both masks apply at once.
  always_comb begin
    set_mask = 2'b00;
    clr_mask = 2'b00;
    if (close_line)   set_mask[wr_bank] = 1'b1;
    if (release_line) clr_mask[rd_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      full     <= 2'b00;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      line_err <= 1'b0;
    end else begin
      full <= (full | set_mask) & ~clr_mask;
      if (accept && (stream.s_last != at_end)) line_err <= 1'b1;
      case (state)
        FILL: begin
          if (close_line) begin
            wr_bank <= ~wr_bank;
            wr_addr <= '0;
            state   <= full[~wr_bank] ? WAIT : FILL;
          end else if (accept) begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        WAIT: if (!full[wr_bank]) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

  // Display side: shown/sel track which RAM output register is valid to present.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank  <= 1'b0;
      sel      <= 1'b0;
      shown    <= 1'b0;
      underrun <= 1'b0;
    end else if (pix_en) begin
      shown <= active && full[rd_bank];
      sel   <= rd_bank;
      if (active && !full[rd_bank]) underrun <= 1'b1;
      if (release_line) rd_bank <= ~rd_bank;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_ram #(
      .DEPTH (H_ACTIVE),
      .DATA_W(DATA_W),
      .AW    (AW)
    ) u_ram (
      .clk  (clk),
      .we   (accept && (wr_bank == b[0])),
      .waddr(wr_addr),
      .wdata(stream.s_data),
      .re   (active),
      .raddr(count[AW-1:0]),
      .rdata(rdata[b])
    );
  end

  assign pixel = shown ? rdata[sel] : '0;
  assign red   = pixel[23:16];
  assign green = pixel[15:8];
  assign blue  = pixel[7:0];

endmodule

// File: tb/tb_line_buffer.sv
// Bench for line_buffer: directed line scenarios plus a randomized writer/reader
// phase, all checked every cycle against a bank-level behavioural model.
module tb_line_buffer;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [10:0] count;
  logic [9:0]  reset_count;
  logic [7:0]  red, green, blue;
  logic        underrun, line_err;
  bit          checking = 1'b0;
  int          checks = 0;
  int          fails = 0;

  line_buffer_if #(.DATA_W(DATA_W)) bus ();

  line_buffer #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stream     (bus.slave),
    .pix_en     (pix_en),
    .count      (count),
    .reset_count(reset_count),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .underrun   (underrun),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  // Reference model: two banks of pixels with full flags, a writer cursor and
  // a reader bank, all updated with the values seen just before each edge.
  logic [DATA_W-1:0] m_mem   [2][H_ACTIVE];
  bit                m_known [2][H_ACTIVE];
  bit   [1:0]        m_full;
  bit                m_wb, m_rb, m_ready, m_under, m_lerr, m_pix_known;
  int                m_wa;
  logic [DATA_W-1:0] m_pix;

  always @(posedge clk) begin
    bit [1:0] f;
    bit       act;
    if (rst) begin
      m_full = 2'b00; m_wb = 0; m_rb = 0; m_wa = 0; m_ready = 1;
      m_under = 0; m_lerr = 0; m_pix = '0; m_pix_known = 1;
    end else begin
      f   = m_full;
      act = pix_en && (count < H_ACTIVE) && (reset_count < V_ACTIVE);
      if (pix_en) begin
        if (act && f[m_rb]) begin
          m_pix       = m_mem[m_rb][count];
          m_pix_known = m_known[m_rb][count];
          if (count == H_ACTIVE - 1) begin
            m_full[m_rb] = 0;
            m_rb = !m_rb;
          end
        end else begin
          m_pix = '0;
          m_pix_known = 1;
          if (act) m_under = 1;
        end
      end
      if (m_ready) begin
        if (bus.s_valid) begin
          m_mem[m_wb][m_wa]   = bus.s_data;
          m_known[m_wb][m_wa] = 1;
          if (bus.s_last != (m_wa == H_ACTIVE - 1)) m_lerr = 1;
          if (bus.s_last || m_wa == H_ACTIVE - 1) begin
            m_full[m_wb] = 1;
            m_ready = !f[!m_wb];
            m_wb = !m_wb;
            m_wa = 0;
          end else begin
            m_wa++;
          end
        end
      end else begin
        m_ready = !f[m_wb];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking && !rst) begin
      checkOutput("s_ready", 32'(bus.s_ready), 32'(m_ready));
      checkOutput("underrun", 32'(underrun), 32'(m_under));
      checkOutput("line_err", 32'(line_err), 32'(m_lerr));
      if (m_pix_known) checkOutput("pixel", 32'({red, green, blue}), 32'(m_pix));
    end
  end

  // Streams n beats of base+i; s_last on beat lastAt (-1 for none).
  task automatic applyStimulus(input int n, input int lastAt, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int t;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = DATA_W'(base + i);
      bus.s_last  = (i == lastAt);
      acc = 0;
      t = 0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.s_ready;
        @(posedge clk);
        #1;
        t++;
        if (!acc && t > 8000) begin
          checkOutput("beat_accept_timeout", 32'(t), 32'(8000));
          bus.s_valid = 1'b0;
          bus.s_last  = 1'b0;
          return;
        end
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic runDisplayLine(input int line, input int probeAt, input logic [23:0] probeVal);
    for (int c = 0; c < H_TOTAL; c++) begin
      pix_en      = 1'b1;
      count       = 11'(c);
      reset_count = 10'(line);
      @(posedge clk);
      #1;
      pix_en = 1'b0;
      if (c == probeAt) begin
        @(negedge clk);
        checkOutput("probe_pixel", 32'({red, green, blue}), 32'(probeVal));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    pix_en = 1'b0; count = '0; reset_count = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("reset_pixel", 32'({red, green, blue}), 32'd0);
    checkOutput("reset_underrun", 32'(underrun), 32'd0);
    checkOutput("reset_line_err", 32'(line_err), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(H_ACTIVE, H_ACTIVE - 1, 0, 0);
    @(negedge clk);
    checkOutput("line1_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("line1_err", 32'(line_err), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(H_ACTIVE, H_ACTIVE - 1, 2000, 0);
    @(negedge clk);
    checkOutput("both_full_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;

    fork
      applyStimulus(H_ACTIVE, H_ACTIVE - 1, 5000, 0);
      runDisplayLine(0, 300, 24'd300);
    join
    checkOutput("line0_underrun", 32'(underrun), 32'd0);
    runDisplayLine(1, 10, 24'd2010);
    runDisplayLine(2, 20, 24'd5020);

    applyStimulus(H_ACTIVE, 399, 7000, 0);
    @(negedge clk);
    checkOutput("short_line_err", 32'(line_err), 32'd1);
    @(posedge clk);
    #1;
    runDisplayLine(3, 450, 24'd2450);
    applyStimulus(400, 399, 9000, 0);
    runDisplayLine(4, 5, 24'd7405);

    pulseReset();
    runDisplayLine(0, 0, 24'd0);
    checkOutput("no_write_underrun", 32'(underrun), 32'd1);

    pulseReset();
    applyStimulus(300, -1, 11000, 0);
    pulseReset();
    @(negedge clk);
    checkOutput("midline_rst_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(H_ACTIVE, H_ACTIVE - 1, 12000, 0);
    runDisplayLine(5, 300, 24'd12300);
    checkOutput("refill_line_err", 32'(line_err), 32'd0);
    checkOutput("refill_underrun", 32'(underrun), 32'd0);

    fork
      begin
        for (int l = 0; l < 6; l++) begin
          int kind, n, base;
          kind = $urandom_range(0, 3);
          base = $urandom_range(0, 1 << 20);
          if (kind == 2) begin
            n = $urandom_range(1, H_ACTIVE - 1);
            applyStimulus(n, n - 1, base, 1);
          end else if (kind == 3) begin
            applyStimulus(H_ACTIVE, -1, base, 1);
          end else begin
            applyStimulus(H_ACTIVE, H_ACTIVE - 1, base, 1);
          end
        end
      end
      begin
        runDisplayLine(620, -1, 24'd0);
        for (int l = 0; l < 9; l++) runDisplayLine($urandom_range(0, V_ACTIVE - 1), -1, 24'd0);
      end
    join

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
